// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 responder: command codes, bit positions,
// FSM states, sizes and the key-scan byte layout helper.
package tm1638_pkg;

    localparam int unsigned C_RAM_BYTES = 16;
    localparam int unsigned C_KEY_BYTES = 4;
    localparam int unsigned C_ADDR_W    = 4;
    localparam int unsigned C_KEY_BITS  = C_KEY_BYTES * 8;
    localparam int unsigned C_RD_CNT_W  = 6;

    // Command field codes in bits [7:6] of the first byte of a frame
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Data-command and display-command bit indices
    localparam int unsigned DCMD_READ_BIT  = 1;
    localparam int unsigned DCMD_FIXED_BIT = 2;
    localparam int unsigned DISP_ON_BIT    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    // Key byte n: bit0 = keys[n], bit4 = keys[n+4], all other bits zero
    function automatic logic [C_KEY_BITS-1:0] key_bytes(input logic [7:0] keys);
        logic [C_KEY_BITS-1:0] r;
        r = '0;
        for (int n = 0; n < int'(C_KEY_BYTES); n++) begin
            r[8*n]     = keys[n];
            r[8*n + 4] = keys[n + 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-flop synchroniser with rise/fall pulse detection on the synchronised level.
// Ports: clk, rst (sync, active-high), d (async input),
//        rise_c / fall_c (one-clk pulses, combinational from registers).
module tm1638_sync_edge #(
    parameter int unsigned C_SYNC  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [C_SYNC-1:0] chain;
    logic              prev;
    logic              q;

    assign q = chain[C_SYNC-1];

    // Synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {C_SYNC{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[C_SYNC-2:0], d};
            prev  <= q;
        end
    end

    assign rise_c = q & ~prev;
    assign fall_c = ~q & prev;

endmodule

// File: rtl/tm1638_responder.sv
// Device-side TM1638 emulator: decodes data/address/display commands from the
// STB/CLK/DIO link, holds 16-byte display RAM and returns 4 key-scan bytes.
// Ports: CK_i/RST_i clock and sync reset; SS_i/SCLK_i/MOSI_i serial input;
//        MISO_o/MISO_EN_o DIO return path; KEYS_i key states;
//        DISP_RAM_o display RAM; DISP_ON_o/BRIGHT_o display control;
//        CMD_STB_o pulse per completed command byte.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int unsigned C_SYNC = 2
) (
    input  logic                       CK_i,
    input  logic                       RST_i,
    input  logic                       SS_i,
    input  logic                       SCLK_i,
    input  logic                       MOSI_i,
    output logic                       MISO_o,
    output logic                       MISO_EN_o,
    input  logic [7:0]                 KEYS_i,
    output logic [C_RAM_BYTES*8-1:0]   DISP_RAM_o,
    output logic                       DISP_ON_o,
    output logic [2:0]                 BRIGHT_o,
    output logic                       CMD_STB_o
);

    logic sclk_rise_c, sclk_fall_c, ss_rise_c, ss_fall_c;
    logic [C_SYNC-1:0] mosi_sync;
    logic              mosi_s;

    // SS chain resets to "asserted" so a frame already in progress at reset
    // produces no fall edge and is ignored until the next genuine SS fall.
    tm1638_sync_edge #(.C_SYNC(C_SYNC), .RST_VAL(1'b0)) u_ss (
        .clk(CK_i), .rst(RST_i), .d(SS_i), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
    );

    tm1638_sync_edge #(.C_SYNC(C_SYNC), .RST_VAL(1'b1)) u_sclk (
        .clk(CK_i), .rst(RST_i), .d(SCLK_i), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    // MOSI goes through the same depth so it stays aligned with SCLK edges
    always_ff @(posedge CK_i) begin
        if (RST_i) mosi_sync <= '0;
        else       mosi_sync <= {mosi_sync[C_SYNC-2:0], MOSI_i};
    end
    assign mosi_s = mosi_sync[C_SYNC-1];

    state_t                     state, state_d;
    logic [2:0]                 bit_cnt;
    logic [7:0]                 shreg;
    logic [7:0]                 new_byte_c;
    logic                       byte_done_c;
    logic [C_ADDR_W-1:0]        ptr;
    logic                       mode_fixed;
    logic [C_RAM_BYTES-1:0][7:0] ram;
    logic [C_KEY_BITS-1:0]      key_sr;
    logic [C_RD_CNT_W-1:0]      rd_cnt;

    // FSM state register
    always_ff @(posedge CK_i) begin
        if (RST_i) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Next-state and byte-completion decode
    always_comb begin
        state_d     = state;
        new_byte_c  = {mosi_s, shreg[7:1]};
        byte_done_c = (state != ST_IDLE) && sclk_rise_c && (bit_cnt == 3'd7) && !ss_rise_c;

        case (state)
            ST_IDLE: if (ss_fall_c) state_d = ST_CMD;
            ST_CMD: begin
                if (byte_done_c) begin
                    case (new_byte_c[7:6])
                        CMD_DATA: state_d = new_byte_c[DCMD_READ_BIT] ? ST_RDATA : ST_IGNORE;
                        CMD_ADDR: state_d = ST_WDATA;
                        default:  state_d = ST_IGNORE;
                    endcase
                end
            end
            default: ;
        endcase

        if (ss_rise_c) state_d = ST_IDLE;
    end

    // Shift register, command side effects, RAM writes and read-back driver
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            ptr        <= '0;
            mode_fixed <= 1'b0;
            ram        <= '0;
            key_sr     <= '0;
            rd_cnt     <= '0;
            DISP_ON_o  <= 1'b0;
            BRIGHT_o   <= '0;
            MISO_o     <= 1'b0;
            MISO_EN_o  <= 1'b0;
            CMD_STB_o  <= 1'b0;
        end else begin
            CMD_STB_o <= 1'b0;

            if (ss_fall_c) begin
                bit_cnt <= '0;
            end else if (state != ST_IDLE && sclk_rise_c) begin
                shreg   <= new_byte_c;
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (byte_done_c && state == ST_CMD) begin
                CMD_STB_o <= 1'b1;
                case (new_byte_c[7:6])
                    CMD_DATA: begin
                        mode_fixed <= new_byte_c[DCMD_FIXED_BIT];
                        if (new_byte_c[DCMD_READ_BIT]) begin
                            key_sr <= key_bytes(KEYS_i);
                            rd_cnt <= '0;
                        end
                    end
                    CMD_DISP: begin
                        DISP_ON_o <= new_byte_c[DISP_ON_BIT];
                        BRIGHT_o  <= new_byte_c[2:0];
                    end
                    CMD_ADDR: ptr <= new_byte_c[C_ADDR_W-1:0];
                    default: ;
                endcase
            end

            if (byte_done_c && state == ST_WDATA) begin
                ram[ptr] <= new_byte_c;
                if (!mode_fixed) ptr <= ptr + C_ADDR_W'(1);
            end

            // Past the 32nd bit the line stays driven low
            if (state == ST_RDATA && sclk_fall_c && !ss_rise_c) begin
                MISO_EN_o <= 1'b1;
                if (!rd_cnt[C_RD_CNT_W-1]) begin
                    MISO_o <= key_sr[rd_cnt[C_RD_CNT_W-2:0]];
                    rd_cnt <= rd_cnt + C_RD_CNT_W'(1);
                end else begin
                    MISO_o <= 1'b0;
                end
            end

            if (ss_rise_c) begin
                MISO_EN_o <= 1'b0;
                MISO_o    <= 1'b0;
            end
        end
    end

    assign DISP_RAM_o = ram;

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder: directed frames followed by
// randomised frames, checked against a frame-level reference model.
module tb_tm1638_responder;

    logic         CK_i = 1'b0;
    logic         RST_i, SS_i, SCLK_i, MOSI_i;
    logic [7:0]   KEYS_i;
    logic         MISO_o, MISO_EN_o, DISP_ON_o, CMD_STB_o;
    logic [127:0] DISP_RAM_o;
    logic [2:0]   BRIGHT_o;

    tm1638_responder #(.C_SYNC(2)) dut (
        .CK_i(CK_i), .RST_i(RST_i), .SS_i(SS_i), .SCLK_i(SCLK_i), .MOSI_i(MOSI_i),
        .MISO_o(MISO_o), .MISO_EN_o(MISO_EN_o), .KEYS_i(KEYS_i),
        .DISP_RAM_o(DISP_RAM_o), .DISP_ON_o(DISP_ON_o), .BRIGHT_o(BRIGHT_o),
        .CMD_STB_o(CMD_STB_o)
    );

    always #5 CK_i = ~CK_i;

    int n_cmp  = 0;
    int n_fail = 0;
    int stb_cnt = 0;

    always @(posedge CK_i) if (CMD_STB_o === 1'b1) stb_cnt++;

    // Reference model state
    logic [7:0] m_ram [16];
    logic       m_fixed;
    logic       m_on;
    logic [2:0] m_bright;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] m_packed();
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = m_ram[n];
        return r;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 16; n++) m_ram[n] = 8'h00;
        m_fixed  = 1'b0;
        m_on     = 1'b0;
        m_bright = 3'd0;
    endtask

    // Whole-frame effect: first byte is the command, later bytes are data
    task automatic model_frame(input logic [7:0] b[$]);
        int a;
        if (b.size() == 0) return;
        case (b[0][7:6])
            2'b01: m_fixed = b[0][2];
            2'b10: begin m_on = b[0][3]; m_bright = b[0][2:0]; end
            2'b11: begin
                a = int'(b[0][3:0]);
                for (int i = 1; i < b.size(); i++) begin
                    m_ram[a] = b[i];
                    if (!m_fixed) a = (a + 1) % 16;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] expected_keys(input logic [7:0] k);
        logic [31:0] e;
        e = 32'h0;
        for (int n = 0; n < 4; n++) begin
            e[8*n]     = k[n];
            e[8*n + 4] = k[n + 4];
        end
        return e;
    endfunction

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            SCLK_i = 1'b0;
            MOSI_i = b[i];
            #50;
            SCLK_i = 1'b1;
            #50;
        end
    endtask

    task automatic frame(input logic [7:0] b[$]);
        SS_i = 1'b0;
        #50;
        foreach (b[i]) send_bits(b[i], 8);
        SS_i = 1'b1;
        #100;
        model_frame(b);
    endtask

    // Read frame with nbits clocked back; checks enable timing around SS rise
    task automatic read_frame(input logic [7:0] cmd, input logic [7:0] keys, input int nbits,
                              output logic [63:0] got, output logic en_all);
        logic [7:0] q[$];
        got    = '0;
        en_all = 1'b1;
        KEYS_i = keys;
        SS_i   = 1'b0;
        #50;
        send_bits(cmd, 8);
        KEYS_i = ~keys;
        for (int i = 0; i < nbits; i++) begin
            SCLK_i = 1'b0;
            #45;
            got[i] = MISO_o;
            en_all = en_all & MISO_EN_o;
            #5;
            SCLK_i = 1'b1;
            #50;
        end
        SS_i = 1'b1;
        #35;
        check("miso_en_after_ss_rise", 128'(MISO_EN_o), 128'(1'b0));
        #65;
        q = {cmd};
        model_frame(q);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  q[$];
        logic [63:0] got;
        logic        en_all;
        logic [7:0]  keys, cmd;
        int          s0, r, nb;

        RST_i = 1'b1; SS_i = 1'b1; SCLK_i = 1'b1; MOSI_i = 1'b0; KEYS_i = 8'h00;
        model_reset();
        #40;
        RST_i = 1'b0;
        #100;

        check("reset_ram",     DISP_RAM_o, 128'h0);
        check("reset_disp_on", 128'(DISP_ON_o), 128'(1'b0));
        check("reset_bright",  128'(BRIGHT_o), 128'(3'd0));
        check("reset_miso",    128'({MISO_EN_o, MISO_o}), 128'(2'b00));
        check("reset_stb",     128'(stb_cnt), 128'(0));

        // 1: auto-increment fill of the whole RAM
        q = {8'h40}; frame(q);
        q = {8'hC0};
        for (int n = 0; n < 16; n++) q.push_back(8'(n));
        frame(q);
        check("t1_fill", DISP_RAM_o, m_packed());

        // 2: fixed address
        model_reset();
        RST_i = 1'b1; #20; RST_i = 1'b0; #100;
        q = {8'h44}; frame(q);
        q = {8'hC5, 8'hAA, 8'h55}; frame(q);
        check("t2_fixed", DISP_RAM_o, m_packed());
        check("t2_fixed_byte5", 128'(DISP_RAM_o[47:40]), 128'(8'h55));

        // 3: wrap from 15 to 0
        q = {8'h40}; frame(q);
        q = {8'hCF, 8'h11, 8'h22}; frame(q);
        check("t3_wrap", DISP_RAM_o, m_packed());

        // 4: display control, one strobe per command byte
        s0 = stb_cnt;
        q = {8'h8F}; frame(q);
        check("t4_on",  128'({DISP_ON_o, BRIGHT_o}), 128'(4'hF));
        check("t4_stb1", 128'(stb_cnt - s0), 128'(1));
        s0 = stb_cnt;
        q = {8'h80}; frame(q);
        check("t4_off", 128'({DISP_ON_o, BRIGHT_o}), 128'(4'h0));
        check("t4_stb2", 128'(stb_cnt - s0), 128'(1));

        // 5: key read, plus 8 extra bits beyond the 32 that must read 0
        read_frame(8'h42, 8'h21, 40, got, en_all);
        check("t5_keys", 128'(got[39:0]), 128'({8'h00, expected_keys(8'h21)}));
        check("t5_en",   128'(en_all), 128'(1'b1));

        // 6: partial byte discarded on SS rise
        q = {8'h40}; frame(q);
        SS_i = 1'b0; #50;
        send_bits(8'hC3, 8);
        send_bits(8'hAA, 8);
        send_bits(8'h77, 4);
        SS_i = 1'b1; #100;
        q = {8'hC3, 8'hAA}; model_frame(q);
        check("t6_partial", DISP_RAM_o, m_packed());

        // 6b: reset pulse mid-byte; rest of frame ignored
        q = {8'h8A}; frame(q);
        SS_i = 1'b0; #50;
        send_bits(8'hC0, 8);
        send_bits(8'h5A, 4);
        RST_i = 1'b1; #20; RST_i = 1'b0;
        send_bits(8'h5A, 4);
        send_bits(8'hC1, 8);
        send_bits(8'h99, 8);
        SS_i = 1'b1; #100;
        model_reset();
        check("t6_rst_ram", DISP_RAM_o, 128'h0);
        check("t6_rst_ctl", 128'({MISO_EN_o, DISP_ON_o, BRIGHT_o}), 128'(5'h0));

        // Randomised frames against the model
        for (int it = 0; it < 30; it++) begin
            r = int'($urandom_range(0, 5));
            q = {};
            case (r)
                0: begin
                    q.push_back(8'h40 | 8'($urandom_range(0, 1) << 2));
                    if ($urandom_range(0, 1) == 1) q.push_back(8'($urandom));
                end
                1: q.push_back(8'h80 | 8'($urandom_range(0, 15)));
                2: begin
                    q.push_back(8'($urandom) & 8'h3F);
                    q.push_back(8'($urandom));
                end
                default: begin
                    q.push_back(8'hC0 | 8'($urandom_range(0, 15)));
                    nb = int'($urandom_range(1, 6));
                    for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
                end
            endcase
            s0 = stb_cnt;
            frame(q);
            check("rnd_ram", DISP_RAM_o, m_packed());
            check("rnd_ctl", 128'({DISP_ON_o, BRIGHT_o}), 128'({m_on, m_bright}));
            check("rnd_stb", 128'(stb_cnt - s0), 128'(1));
        end

        // Randomised key reads, in both addressing modes
        for (int it = 0; it < 4; it++) begin
            keys = 8'($urandom);
            cmd  = 8'h42 | 8'($urandom_range(0, 1) << 2);
            read_frame(cmd, keys, 32, got, en_all);
            check("rnd_keys", 128'(got[31:0]), 128'(expected_keys(keys)));
            check("rnd_key_en", 128'(en_all), 128'(1'b1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
